// File: rtl/commit_queue.sv
// In-order completion buffer feeding the commit stage: allocates slots at issue, records
// out-of-order writebacks by id, presents the oldest entries as commit candidates.
// Optional COMMIT_QUEUE_WB_BYPASS_EN forwards same-cycle writebacks to the commit candidates.
module commit_queue #(
  parameter int NR_ENTRIES      = 8,
  parameter int NR_COMMIT_PORTS = 2,
  parameter int NR_WB_PORTS     = 4,
  parameter int PAYLOAD_W       = 64,
  parameter int XLEN            = 64,
  localparam int TRANS_ID_BITS  = $clog2(NR_ENTRIES)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_i,
  input  logic                                     issue_valid_i,
  input  logic [PAYLOAD_W-1:0]                     issue_payload_i,
  output logic                                     issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                 issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                   wb_valid_i,
  input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]     wb_trans_id_i,
  input  logic [NR_WB_PORTS*XLEN-1:0]              wb_result_i,
  input  logic [NR_WB_PORTS-1:0]                   wb_ex_valid_i,
  output logic [NR_COMMIT_PORTS-1:0]               commit_valid_o,
  output logic [NR_COMMIT_PORTS*PAYLOAD_W-1:0]     commit_payload_o,
  output logic [NR_COMMIT_PORTS*XLEN-1:0]          commit_result_o,
  output logic [NR_COMMIT_PORTS-1:0]               commit_ex_valid_o,
  output logic [NR_COMMIT_PORTS*TRANS_ID_BITS-1:0] commit_trans_id_o,
  input  logic [NR_COMMIT_PORTS-1:0]               commit_ack_i,
  output logic                                     empty_o
);

  localparam int CNT_W = TRANS_ID_BITS + 1;

  logic [TRANS_ID_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [NR_ENTRIES-1:0]    alloc_q, alloc_d, done_q, done_d, ex_q, ex_d;
  logic [XLEN-1:0]          result_q  [NR_ENTRIES];
  logic [XLEN-1:0]          result_d  [NR_ENTRIES];
  logic [PAYLOAD_W-1:0]     payload_q [NR_ENTRIES];
  logic [PAYLOAD_W-1:0]     payload_d [NR_ENTRIES];

  logic [NR_ENTRIES-1:0]    wbHit, wbEx;
  logic [XLEN-1:0]          wbResult [NR_ENTRIES];

  logic [TRANS_ID_BITS-1:0] candId [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0] candDone, candValid, ackLegal;
  logic                     ackChain;
  logic [CNT_W-1:0]         ackCnt;
  logic                     issueFire;

  // Resolve writeback ports per slot; iterating upward lets the highest port index win.
  always_comb begin
    wbHit = '0;
    wbEx  = '0;
    for (int s = 0; s < NR_ENTRIES; s++) wbResult[s] = '0;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      if (wb_valid_i[p] && alloc_q[wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS]]) begin
        wbHit[wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS]]    = 1'b1;
        wbEx[wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS]]     = wb_ex_valid_i[p];
        wbResult[wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS]] = wb_result_i[p*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    commit_payload_o  = '0;
    commit_result_o   = '0;
    commit_ex_valid_o = '0;
    commit_trans_id_o = '0;
    candDone          = '0;
    candValid         = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      candId[i] = head_q + TRANS_ID_BITS'(i);
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
      candDone[i]          = done_q[candId[i]] | wbHit[candId[i]];
      commit_ex_valid_o[i] = wbHit[candId[i]] ? wbEx[candId[i]] : ex_q[candId[i]];
      commit_result_o[i*XLEN +: XLEN] = wbHit[candId[i]] ? wbResult[candId[i]]
                                                         : result_q[candId[i]];
`else
      candDone[i]          = done_q[candId[i]];
      commit_ex_valid_o[i] = ex_q[candId[i]];
      commit_result_o[i*XLEN +: XLEN] = result_q[candId[i]];
`endif
      // The count guard keeps a stale slot beyond the tail from looking like a candidate.
      candValid[i] = alloc_q[candId[i]] & candDone[i] & (count_q > CNT_W'(i));
      commit_payload_o[i*PAYLOAD_W +: PAYLOAD_W]         = payload_q[candId[i]];
      commit_trans_id_o[i*TRANS_ID_BITS +: TRANS_ID_BITS] = candId[i];
    end
  end

  assign commit_valid_o = candValid;

  // Acks must be valid and contiguous from candidate 0; anything else is dropped.
  always_comb begin
    ackLegal = '0;
    ackCnt   = '0;
    ackChain = 1'b1;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      ackLegal[i] = commit_ack_i[i] & candValid[i] & ackChain;
      ackChain    = ackLegal[i];
      if (ackLegal[i]) ackCnt = ackCnt + CNT_W'(1);
    end
  end

  assign issue_ready_o    = (count_q != CNT_W'(NR_ENTRIES));
  assign issueFire        = issue_valid_i & issue_ready_o;
  assign issue_trans_id_o = tail_q;
  assign empty_o          = (count_q == '0);

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    alloc_d   = alloc_q;
    done_d    = done_q;
    ex_d      = ex_q;
    result_d  = result_q;
    payload_d = payload_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      alloc_d = '0;
      done_d  = '0;
      ex_d    = '0;
    end else begin
      for (int s = 0; s < NR_ENTRIES; s++) begin
        if (wbHit[s]) begin
          done_d[s]   = 1'b1;
          ex_d[s]     = wbEx[s];
          result_d[s] = wbResult[s];
        end
      end
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (ackLegal[i]) begin
          alloc_d[candId[i]] = 1'b0;
          done_d[candId[i]]  = 1'b0;
        end
      end
      // The tail slot is never allocated while ready, so it cannot collide with an acked slot.
      if (issueFire) begin
        alloc_d[tail_q]   = 1'b1;
        done_d[tail_q]    = 1'b0;
        ex_d[tail_q]      = 1'b0;
        payload_d[tail_q] = issue_payload_i;
        tail_d            = tail_q + TRANS_ID_BITS'(1);
      end
      head_d  = head_q + ackCnt[TRANS_ID_BITS-1:0];
      count_d = count_q + CNT_W'(issueFire) - ackCnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      done_q  <= '0;
      ex_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      alloc_q <= alloc_d;
      done_q  <= done_d;
      ex_q    <= ex_d;
    end
  end

  // Data arrays carry no reset; their contents only matter while the slot is allocated.
  always_ff @(posedge clk_i) begin
    result_q  <= result_d;
    payload_q <= payload_d;
  end

  if (NR_COMMIT_PORTS > 1) begin : gAckOrder
    ackInOrder: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 commit_ack_i[1] |-> commit_ack_i[0]);
  end

endmodule

// File: tb/tb_commit_queue.sv
// Self-checking bench for commit_queue: directed scenarios plus randomized traffic against a
// queue-based reference model. Honours COMMIT_QUEUE_WB_BYPASS_EN when defined.
module tb_commit_queue;

  localparam int N  = 8;
  localparam int TB = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          issue_valid_i;
  logic [63:0]   issue_payload_i;
  logic          issue_ready_o;
  logic [2:0]    issue_trans_id_o;
  logic [3:0]    wb_valid_i;
  logic [11:0]   wb_trans_id_i;
  logic [255:0]  wb_result_i;
  logic [3:0]    wb_ex_valid_i;
  logic [1:0]    commit_valid_o;
  logic [127:0]  commit_payload_o;
  logic [127:0]  commit_result_o;
  logic [1:0]    commit_ex_valid_o;
  logic [5:0]    commit_trans_id_o;
  logic [1:0]    commit_ack_i;
  logic          empty_o;

  commit_queue #(
    .NR_ENTRIES(8), .NR_COMMIT_PORTS(2), .NR_WB_PORTS(4), .PAYLOAD_W(64), .XLEN(64)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_payload_i(issue_payload_i),
    .issue_ready_o(issue_ready_o), .issue_trans_id_o(issue_trans_id_o),
    .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i),
    .wb_result_i(wb_result_i), .wb_ex_valid_i(wb_ex_valid_i),
    .commit_valid_o(commit_valid_o), .commit_payload_o(commit_payload_o),
    .commit_result_o(commit_result_o), .commit_ex_valid_o(commit_ex_valid_o),
    .commit_trans_id_o(commit_trans_id_o), .commit_ack_i(commit_ack_i),
    .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          id;
    logic [63:0] pay;
    bit          done;
    bit          ex;
    logic [63:0] res;
  } entry_t;

  entry_t robQ[$];
  int     nextId;
  int     vectors = 0;
  int     miscompares = 0;
  bit     expValid [2];
  int     expId [2];
  bit     expEmpty, expReady;
  int     expTail;
  int     ackN;

  function automatic void model_reset();
    robQ.delete();
    nextId = 0;
  endfunction

  function automatic void model_wb();
    int id;
    for (int p = 0; p < 4; p++) begin
      if (wb_valid_i[p]) begin
        id = int'(wb_trans_id_i[p*TB +: TB]);
        foreach (robQ[k]) begin
          if (robQ[k].id == id) begin
            robQ[k].done = 1'b1;
            robQ[k].ex   = wb_ex_valid_i[p];
            robQ[k].res  = wb_result_i[p*64 +: 64];
          end
        end
      end
    end
  endfunction

  // Expected outputs for the current inputs, seen from the queue's program order.
  function automatic void calc_expect();
    int hd;
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
    model_wb();
`endif
    hd = (robQ.size() > 0) ? robQ[0].id : nextId;
    for (int i = 0; i < 2; i++) begin
      expId[i]    = (hd + i) % N;
      expValid[i] = (i < robQ.size()) && robQ[i].done;
    end
    expEmpty = (robQ.size() == 0);
    expReady = (robQ.size() < N);
    expTail  = nextId;
    ackN = 0;
    if (commit_ack_i[0] && expValid[0]) begin
      ackN = 1;
      if (commit_ack_i[1] && expValid[1]) ackN = 2;
    end
  endfunction

  task automatic advance();
    calc_expect();
`ifndef COMMIT_QUEUE_WB_BYPASS_EN
    model_wb();
`endif
    if (flush_i) model_reset();
    else begin
      repeat (ackN) void'(robQ.pop_front());
      if (issue_valid_i && expReady) begin
        robQ.push_back('{id: nextId, pay: issue_payload_i, done: 1'b0, ex: 1'b0, res: '0});
        nextId = (nextId + 1) % N;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    flush_i         = 1'b0;
    issue_valid_i   = 1'b0;
    issue_payload_i = '0;
    wb_valid_i      = '0;
    wb_trans_id_i   = '0;
    wb_result_i     = '0;
    wb_ex_valid_i   = '0;
    commit_ack_i    = '0;
  endtask

  task automatic set_wb(input int p, input int id, input logic [63:0] res, input logic ex);
    wb_valid_i[p]            = 1'b1;
    wb_trans_id_i[p*TB +: TB] = 3'(id);
    wb_result_i[p*64 +: 64]  = res;
    wb_ex_valid_i[p]         = ex;
  endtask

  task automatic do_flush();
    clear_inputs();
    flush_i = 1'b1;
    advance();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    vectors++; if (issue_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 1", issue_ready_o); end
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty: got %b expected 1", empty_o); end
    vectors++; if (commit_valid_o !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 00", commit_valid_o); end
    vectors++; if (issue_trans_id_o !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_tid: got %0d expected 0", issue_trans_id_o); end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_inorder();
    logic [63:0] payA, r0;
    payA = 64'hA0A0_0000_1111_2222;
    r0   = 64'h0000_0000_0BAD_F00D;
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      issue_valid_i   = 1'b1;
      issue_payload_i = (k == 0) ? payA : 64'(k);
      #2;
      vectors++; if (issue_trans_id_o !== 3'(k)) begin miscompares++; $display("[TB] FAIL t2_tid: got %0d expected %0d", issue_trans_id_o, k); end
      advance();
    end
    clear_inputs();
    set_wb(0, 2, 64'h2222, 1'b0);
    advance();
    clear_inputs();
    set_wb(1, 0, r0, 1'b0);
    advance();
    clear_inputs();
    #2;
    vectors++; if (commit_valid_o !== 2'b01) begin miscompares++; $display("[TB] FAIL t2_valid: got %b expected 01", commit_valid_o); end
    vectors++; if (commit_result_o[63:0] !== r0) begin miscompares++; $display("[TB] FAIL t2_result: got %h expected %h", commit_result_o[63:0], r0); end
    vectors++; if (commit_payload_o[63:0] !== payA) begin miscompares++; $display("[TB] FAIL t2_payload: got %h expected %h", commit_payload_o[63:0], payA); end
    commit_ack_i = 2'b01;
    advance();
    clear_inputs();
    #2;
    vectors++; if (commit_trans_id_o[2:0] !== 3'd1) begin miscompares++; $display("[TB] FAIL t2_head: got %0d expected 1", commit_trans_id_o[2:0]); end
    vectors++; if (commit_valid_o !== 2'b10) begin miscompares++; $display("[TB] FAIL t2_valid_after_ack: got %b expected 10", commit_valid_o); end
    set_wb(3, 1, 64'h1111, 1'b1);
    advance();
    clear_inputs();
    commit_ack_i = 2'b11;
    #2;
    vectors++; if (commit_ex_valid_o[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL t2_ex: got %b expected 1", commit_ex_valid_o[0]); end
    advance();
    clear_inputs();
    #2;
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("[TB] FAIL t2_empty: got %b expected 1", empty_o); end
  endtask

  task automatic test_fill_wrap();
    do_flush();
    for (int k = 0; k < 8; k++) begin
      issue_valid_i   = 1'b1;
      issue_payload_i = {$urandom, $urandom};
      #2;
      vectors++; if (issue_trans_id_o !== 3'(k)) begin miscompares++; $display("[TB] FAIL t3_tid: got %0d expected %0d", issue_trans_id_o, k); end
      advance();
    end
    clear_inputs();
    #2;
    vectors++; if (issue_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL t3_full: got %b expected 0", issue_ready_o); end
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < 4; p++) set_wb(p, c*4 + p, {$urandom, $urandom}, 1'b0);
      advance();
      clear_inputs();
    end
    for (int c = 0; c < 4; c++) begin
      commit_ack_i  = 2'b11;
      issue_valid_i = (c == 0);
      #2;
      vectors++; if (commit_valid_o !== 2'b11) begin miscompares++; $display("[TB] FAIL t3_drain_valid: got %b expected 11", commit_valid_o); end
      if (c == 0) begin
        vectors++; if (issue_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL t3_blocked: got %b expected 0", issue_ready_o); end
      end
      advance();
    end
    clear_inputs();
    #2;
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("[TB] FAIL t3_empty: got %b expected 1", empty_o); end
    vectors++; if (commit_trans_id_o[2:0] !== 3'd0) begin miscompares++; $display("[TB] FAIL t3_head_wrap: got %0d expected 0", commit_trans_id_o[2:0]); end
    vectors++; if (issue_trans_id_o !== 3'd0) begin miscompares++; $display("[TB] FAIL t3_next_id: got %0d expected 0", issue_trans_id_o); end
  endtask

  task automatic test_wrap_issue_ack();
    do_flush();
    for (int k = 0; k < 6; k++) begin issue_valid_i = 1'b1; issue_payload_i = 64'(k); advance(); end
    clear_inputs();
    for (int p = 0; p < 4; p++) set_wb(p, p, 64'(p), 1'b0);
    advance();
    clear_inputs();
    set_wb(0, 4, 64'h4, 1'b0); set_wb(1, 5, 64'h5, 1'b0);
    advance();
    clear_inputs();
    for (int c = 0; c < 3; c++) begin commit_ack_i = 2'b11; advance(); end
    clear_inputs();
    for (int k = 0; k < 7; k++) begin issue_valid_i = 1'b1; issue_payload_i = 64'(100 + k); advance(); end
    clear_inputs();
    set_wb(2, 6, 64'h66, 1'b0); set_wb(3, 7, 64'h77, 1'b0);
    advance();
    clear_inputs();
    issue_valid_i = 1'b1;
    commit_ack_i  = 2'b11;
    #2;
    vectors++; if (issue_trans_id_o !== 3'd5) begin miscompares++; $display("[TB] FAIL t4_tid: got %0d expected 5", issue_trans_id_o); end
    vectors++; if (commit_trans_id_o !== {3'd7, 3'd6}) begin miscompares++; $display("[TB] FAIL t4_cand_ids: got %h expected %h", commit_trans_id_o, {3'd7, 3'd6}); end
    vectors++; if (commit_valid_o !== 2'b11) begin miscompares++; $display("[TB] FAIL t4_valid: got %b expected 11", commit_valid_o); end
    advance();
    clear_inputs();
    #2;
    vectors++; if (commit_trans_id_o[2:0] !== 3'd0) begin miscompares++; $display("[TB] FAIL t4_head: got %0d expected 0", commit_trans_id_o[2:0]); end
    vectors++; if (issue_trans_id_o !== 3'd6) begin miscompares++; $display("[TB] FAIL t4_tail: got %0d expected 6", issue_trans_id_o); end
    vectors++; if (issue_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL t4_ready: got %b expected 1", issue_ready_o); end
    for (int k = 0; k < 2; k++) begin issue_valid_i = 1'b1; advance(); end
    clear_inputs();
    #2;
    vectors++; if (issue_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL t4_count_full: got %b expected 0", issue_ready_o); end
  endtask

  task automatic test_flush();
    do_flush();
    for (int k = 0; k < 5; k++) begin issue_valid_i = 1'b1; advance(); end
    clear_inputs();
    set_wb(0, 0, 64'h1, 1'b0);
    advance();
    clear_inputs();
    flush_i       = 1'b1;
    issue_valid_i = 1'b1;
    commit_ack_i  = 2'b01;
    set_wb(1, 2, 64'h2, 1'b0);
    advance();
    clear_inputs();
    #2;
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("[TB] FAIL t5_empty: got %b expected 1", empty_o); end
    vectors++; if (issue_trans_id_o !== 3'd0) begin miscompares++; $display("[TB] FAIL t5_tid: got %0d expected 0", issue_trans_id_o); end
    vectors++; if (commit_valid_o !== 2'b00) begin miscompares++; $display("[TB] FAIL t5_valid: got %b expected 00", commit_valid_o); end
  endtask

  task automatic test_wb_timing();
    do_flush();
    issue_valid_i = 1'b1;
    advance();
    clear_inputs();
    set_wb(0, 0, 64'h1234, 1'b0);
    set_wb(2, 0, 64'hDEAD, 1'b1);
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
    commit_ack_i = 2'b01;
    #2;
    vectors++; if (commit_valid_o[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL t6_bypass_valid: got %b expected 1", commit_valid_o[0]); end
    vectors++; if (commit_result_o[63:0] !== 64'hDEAD) begin miscompares++; $display("[TB] FAIL t6_bypass_result: got %h expected dead", commit_result_o[63:0]); end
    advance();
`else
    #2;
    vectors++; if (commit_valid_o[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL wb_no_forward: got %b expected 0", commit_valid_o[0]); end
    advance();
    clear_inputs();
    #2;
    vectors++; if (commit_valid_o[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL wb_latency_valid: got %b expected 1", commit_valid_o[0]); end
    vectors++; if (commit_result_o[63:0] !== 64'hDEAD) begin miscompares++; $display("[TB] FAIL wb_port_priority: got %h expected dead", commit_result_o[63:0]); end
    vectors++; if (commit_ex_valid_o[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL wb_ex: got %b expected 1", commit_ex_valid_o[0]); end
    commit_ack_i = 2'b01;
    advance();
`endif
    clear_inputs();
    #2;
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("[TB] FAIL wb_retired: got %b expected 1", empty_o); end
  endtask

  task automatic test_random();
    bit a0, a1;
    do_flush();
    for (int cyc = 0; cyc < 600; cyc++) begin
      clear_inputs();
      flush_i         = ($urandom_range(0, 31) == 0);
      issue_valid_i   = ($urandom_range(0, 99) < 60);
      issue_payload_i = {$urandom, $urandom};
      for (int p = 0; p < 4; p++)
        if ($urandom_range(0, 9) < 4) set_wb(p, $urandom_range(0, 7), {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
      calc_expect();
      a0 = expValid[0] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      a1 = a0 && (expValid[1] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0));
      commit_ack_i = {a1, a0};
      #2;
      if (cyc == 300) begin
        rst_ni = 1'b0;
        #1;
        vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_empty: got %b expected 1", empty_o); end
        vectors++; if (commit_valid_o !== 2'b00) begin miscompares++; $display("[TB] FAIL midrst_valid: got %b expected 00", commit_valid_o); end
        vectors++; if (issue_trans_id_o !== 3'd0) begin miscompares++; $display("[TB] FAIL midrst_tid: got %0d expected 0", issue_trans_id_o); end
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        model_reset();
      end else begin
        calc_expect();
        vectors++; if (issue_ready_o !== expReady) begin miscompares++; $display("[TB] FAIL rnd_ready cyc %0d: got %b expected %b", cyc, issue_ready_o, expReady); end
        vectors++; if (empty_o !== expEmpty) begin miscompares++; $display("[TB] FAIL rnd_empty cyc %0d: got %b expected %b", cyc, empty_o, expEmpty); end
        vectors++; if (issue_trans_id_o !== 3'(expTail)) begin miscompares++; $display("[TB] FAIL rnd_tid cyc %0d: got %0d expected %0d", cyc, issue_trans_id_o, expTail); end
        for (int i = 0; i < 2; i++) begin
          vectors++; if (commit_valid_o[i] !== expValid[i]) begin miscompares++; $display("[TB] FAIL rnd_valid%0d cyc %0d: got %b expected %b", i, cyc, commit_valid_o[i], expValid[i]); end
          vectors++; if (commit_trans_id_o[i*TB +: TB] !== 3'(expId[i])) begin miscompares++; $display("[TB] FAIL rnd_cid%0d cyc %0d: got %0d expected %0d", i, cyc, commit_trans_id_o[i*TB +: TB], expId[i]); end
          if (expValid[i]) begin
            vectors++; if (commit_payload_o[i*64 +: 64] !== robQ[i].pay) begin miscompares++; $display("[TB] FAIL rnd_pay%0d cyc %0d: got %h expected %h", i, cyc, commit_payload_o[i*64 +: 64], robQ[i].pay); end
            vectors++; if (commit_result_o[i*64 +: 64] !== robQ[i].res) begin miscompares++; $display("[TB] FAIL rnd_res%0d cyc %0d: got %h expected %h", i, cyc, commit_result_o[i*64 +: 64], robQ[i].res); end
            vectors++; if (commit_ex_valid_o[i] !== robQ[i].ex) begin miscompares++; $display("[TB] FAIL rnd_ex%0d cyc %0d: got %b expected %b", i, cyc, commit_ex_valid_o[i], robQ[i].ex); end
          end
        end
        advance();
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_inorder();
    test_fill_wrap();
    test_wrap_issue_ack();
    test_flush();
    test_wb_timing();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
